// File: rtl/lms_err_ctrl.sv
// Error/sequencing controller wrapped around a 16-order LMS filter.
// It takes one {xin, din} pair, runs one filter iteration, and returns the saturated error.
module lms_err_ctrl #(
   parameter int X_W      = 16,
   parameter int Y_W      = 16,
   parameter int E_W      = 16,
   parameter int MU_SHIFT = 4,
   parameter int TIMEOUT  = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic signed [X_W-1:0] xin_s,
   input  logic signed [Y_W-1:0] din_s,
   input  logic                  adapt_en,
   output logic                  f_en,
   output logic signed [X_W-1:0] f_xin,
   output logic signed [E_W-1:0] f_err,
   input  logic                  f_update,
   input  logic signed [Y_W-1:0] f_yout,
   output logic                  m_valid,
   output logic signed [Y_W-1:0] m_yout,
   output logic signed [E_W-1:0] m_err,
   output logic [15:0]           sample_cnt,
   output logic [15:0]           sat_cnt,
   output logic                  timeout,
   output logic [2:0]            dbg_state_o
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_CALC, S_OUT} state_t;

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int CW = (E_W > Y_W + 1) ? E_W : Y_W + 1;
   localparam logic signed [E_W-1:0] E_MAX = {1'b0, {(E_W-1){1'b1}}};
   localparam logic signed [E_W-1:0] E_MIN = {1'b1, {(E_W-1){1'b0}}};

   state_t                state_q, state_d;
   logic signed [X_W-1:0] x_q, x_d;
   logic signed [Y_W-1:0] d_q, d_d, y_q, y_d, m_yout_q, m_yout_d;
   logic signed [E_W-1:0] err_q, err_d, f_err_q, f_err_d, m_err_q, m_err_d;
   logic [15:0]           scnt_q, scnt_d, satc_q, satc_d;
   logic                  to_q, to_d;
   logic [TW-1:0]         wait_q, wait_d;
   logic signed [Y_W:0]   e_raw, e_shift;

   // Compare in a width wide enough for both the raw error and the E_W limits.
   function automatic logic is_sat(input logic signed [Y_W:0] v);
      logic signed [CW-1:0] vw;
      vw = CW'(v);
      return (vw > CW'(E_MAX)) || (vw < CW'(E_MIN));
   endfunction

   function automatic logic signed [E_W-1:0] sat_e(input logic signed [Y_W:0] v);
      logic signed [CW-1:0] vw;
      vw = CW'(v);
      if (vw > CW'(E_MAX))      return E_MAX;
      else if (vw < CW'(E_MIN)) return E_MIN;
      else                      return E_W'(vw);
   endfunction

   assign e_raw   = $signed({d_q[Y_W-1], d_q}) - $signed({y_q[Y_W-1], y_q});
   assign e_shift = e_raw >>> MU_SHIFT;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         x_q      <= '0;
         d_q      <= '0;
         y_q      <= '0;
         err_q    <= '0;
         f_err_q  <= '0;
         m_yout_q <= '0;
         m_err_q  <= '0;
         scnt_q   <= '0;
         satc_q   <= '0;
         to_q     <= 1'b0;
         wait_q   <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         d_q      <= d_d;
         y_q      <= y_d;
         err_q    <= err_d;
         f_err_q  <= f_err_d;
         m_yout_q <= m_yout_d;
         m_err_q  <= m_err_d;
         scnt_q   <= scnt_d;
         satc_q   <= satc_d;
         to_q     <= to_d;
         wait_q   <= wait_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      d_d      = d_q;
      y_d      = y_q;
      err_d    = err_q;
      f_err_d  = f_err_q;
      m_yout_d = m_yout_q;
      m_err_d  = m_err_q;
      scnt_d   = scnt_q;
      satc_d   = satc_q;
      to_d     = to_q;
      wait_d   = wait_q;
      case (state_q)
         S_IDLE: begin
            if (s_valid) begin
               x_d     = xin_s;
               d_d     = din_s;
               state_d = S_START;
            end
         end
         S_START: begin
            // Latch the value shown during START so f_err stays put until CALC.
            f_err_d = adapt_en ? err_q : '0;
            wait_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (f_update) begin
               y_d     = f_yout;
               state_d = S_CALC;
            end else if (wait_q == TW'(TIMEOUT - 1)) begin
               to_d    = 1'b1;
               state_d = S_IDLE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_CALC: begin
            m_yout_d = y_q;
            m_err_d  = sat_e(e_raw);
            err_d    = sat_e(e_shift);
            if (is_sat(e_raw) && (satc_q != 16'hFFFF)) satc_d = satc_q + 16'd1;
            state_d  = S_OUT;
         end
         S_OUT: begin
            scnt_d  = scnt_q + 16'd1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign s_ready     = (state_q == S_IDLE);
   assign f_en        = (state_q == S_START);
   assign m_valid     = (state_q == S_OUT);
   assign f_xin       = x_q;
   assign f_err       = (state_q == S_START) ? (adapt_en ? err_q : '0) : f_err_q;
   assign m_yout      = m_yout_q;
   assign m_err       = m_err_q;
   assign sample_cnt  = scnt_q;
   assign sat_cnt     = satc_q;
   assign timeout     = to_q;
   assign dbg_state_o = state_q;

endmodule
